// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the multi-cycle SRAM memory stage.
// Contents:
//   state_e - controller phase: IDLE, LOW (low half-word), HIGH (high half-word), DONE
//   DATA_W  - pipeline data width (32)
//   HALF_W  - external SRAM data width (16)
package sram_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM half-word phase.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   clr      - return the count to 0 (wins over en)
//   en       - advance the count by one
//   tc       - terminal count: the count equals WAIT_CYCLES-1
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_controller.sv
// Multi-cycle MEM stage: one 32-bit word access as two 16-bit SRAM phases
// (low half-word, then high half-word), each held for WAIT_CYCLES cycles.
// ready drops while an access is in flight; the pipeline freezes on ~ready.
// Optional build macro SRAM_RANGE_CHECK_EN: words beyond the SRAM are not
// accessed; the request completes in DONE with err=1 (read_data=0 on a read).
// Without the macro the address is truncated and err is tied 0.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   rd_en, wr_en      - load / store request (both set = store)
//   address           - byte address; BASE_ADDR maps to SRAM word 0
//   write_data        - store data
//   read_data         - registered load result, held between loads
//   ready             - 0 = stall the pipeline
//   sram_addr         - registered half-word address
//   sram_dq_out       - registered write data, sram_dq_oe = drive DQ
//   sram_dq_in        - read data from SRAM
//   sram_we_n         - registered active-low write strobe
//   err               - out-of-range flag during DONE (range-check build only)
module sram_mem_controller
  import sram_ctrl_pkg::*;
#(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  address,
  input  logic [DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]  read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HALF_W-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [HALF_W-1:0]  sram_dq_in,
  output logic               sram_we_n,
  output logic               err
);

  state_e             state_q, state_d;
  logic               wr_q, wr_d;
  logic [DATA_W-1:0]  read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [HALF_W-1:0]  dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;
  logic               cnt_clr, cnt_en, cnt_tc;

  logic               req;
  logic [DATA_W-1:0]  off;
  logic [29:0]        word;
  logic [SRAM_AW-1:0] lo_addr, hi_addr;
  logic               unused_off_bits;

  assign req     = rd_en | wr_en;
  // Wrap-around subtraction; byte offset within the word is dropped.
  assign off     = address - DATA_W'(BASE_ADDR);
  assign word    = off[31:2];
  assign lo_addr = SRAM_AW'({word, 1'b0});
  assign hi_addr = SRAM_AW'({word, 1'b1});
  assign unused_off_bits = ^off[1:0];

`ifdef SRAM_RANGE_CHECK_EN
  logic oor;
  logic err_q, err_d;
  // Any word bit at or above SRAM_AW-1 would not fit in the half-word address.
  assign oor = (word >> (SRAM_AW - 1)) != '0;
`endif

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    we_n_d      = we_n_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
`ifdef SRAM_RANGE_CHECK_EN
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (req) begin
          // Operation is latched so the phases don't depend on rd_en/wr_en later.
          wr_d = wr_en;
`ifdef SRAM_RANGE_CHECK_EN
          if (oor) begin
            state_d = DONE;
            err_d   = 1'b1;
            if (!wr_en) read_data_d = '0;
          end else
`endif
          begin
            state_d     = LOW;
            sram_addr_d = lo_addr;
            we_n_d      = ~wr_en;
            dq_oe_d     = wr_en;
            dq_out_d    = write_data[HALF_W-1:0];
          end
        end
      end
      LOW: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          if (!wr_q) read_data_d[HALF_W-1:0] = sram_dq_in;
          state_d     = HIGH;
          sram_addr_d = hi_addr;
          dq_out_d    = write_data[DATA_W-1:HALF_W];
        end
      end
      HIGH: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          if (!wr_q) read_data_d[DATA_W-1:HALF_W] = sram_dq_in;
          state_d = DONE;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

`ifdef SRAM_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // DONE releases the pipeline; IDLE stalls only when a request is pending.
  assign ready       = (state_q == DONE) | ((state_q == IDLE) & ~req);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;

endmodule
